// File: rtl/vx_barrier_unit_pkg.sv
// Shared types and sizing for the barrier unit: request/release records and
// the one-hot warp helper used by both the entries and the top level.
package vx_barrier_unit_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  typedef struct packed {
    logic               valid;
    logic [NW_BITS-1:0] wid;
    logic [NB_BITS-1:0] id;
    logic [NW_BITS-1:0] size_m1;
  } barrier_req_t;

  typedef struct packed {
    logic                 valid;
    logic [NB_BITS-1:0]   id;
    logic [NUM_WARPS-1:0] wmask;
  } barrier_rel_t;

  function automatic logic [NUM_WARPS-1:0] wid_onehot(input logic [NW_BITS-1:0] wid);
    logic [NUM_WARPS-1:0] v;
    v      = '0;
    v[wid] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/vx_barrier_unit_if.sv
// Warp-control barrier request in, scheduler-facing stall/release state out.
interface vx_barrier_unit_if;
  import vx_barrier_unit_pkg::*;

  logic                 req_valid;
  logic [NW_BITS-1:0]   req_wid;
  logic [NB_BITS-1:0]   req_id;
  logic [NW_BITS-1:0]   req_size_m1;
  logic [NUM_WARPS-1:0] stalled_wmask;
  logic                 release_valid;
  logic [NB_BITS-1:0]   release_id;
  logic [NUM_WARPS-1:0] release_wmask;
  logic [31:0]          perf_releases;

  modport master (
    output req_valid, req_wid, req_id, req_size_m1,
    input  stalled_wmask, release_valid, release_id, release_wmask, perf_releases
  );

  modport slave (
    input  req_valid, req_wid, req_id, req_size_m1,
    output stalled_wmask, release_valid, release_id, release_wmask, perf_releases
  );

endinterface

// File: rtl/vx_barrier_unit_chk.sv
// Simulation-only protocol observations; these log and do not stop simulation,
// since a dropped duplicate is a defined (if unexpected) behaviour.
module vx_barrier_unit_chk
  import vx_barrier_unit_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  input logic                 i_req_valid,
  input logic [NW_BITS-1:0]   i_req_wid,
  input logic [NUM_WARPS-1:0] i_stalled_wmask,
  input logic                 i_dup
);

  a_no_duplicate: assert property (@(posedge clk) disable iff (reset) !i_dup)
    else $info("vx_barrier_unit: duplicate arrival of warp %0d dropped", i_req_wid);

  a_arriver_not_stalled: assert property (@(posedge clk) disable iff (reset)
    i_req_valid |-> !i_stalled_wmask[i_req_wid])
    else $info("vx_barrier_unit: request from stalled warp %0d", i_req_wid);

endmodule

// File: rtl/vx_barrier_unit_entry.sv
// One barrier ID: waiting-warp mask plus arrival count. Decides, for the
// request aimed at it, whether the arriver waits, completes the barrier, or is a duplicate.
module vx_barrier_unit_entry
  import vx_barrier_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_arrive,
  input  logic [NW_BITS-1:0]   i_wid,
  input  logic [NW_BITS-1:0]   i_size_m1,
  output logic [NUM_WARPS-1:0] o_rel_wmask,
  output logic                 o_fire,
  output logic                 o_wait,
  output logic                 o_dup
);

  logic [NUM_WARPS-1:0] r_wait_mask;
  logic [NW_BITS-1:0]   r_arrive_cnt;
  logic [NUM_WARPS-1:0] w_onehot;

  assign w_onehot    = wid_onehot(i_wid);
  assign o_dup       = i_arrive & (|(r_wait_mask & w_onehot));
  // The count is compared against this request's own size, not a stored one.
  assign o_fire      = i_arrive & ~o_dup & (r_arrive_cnt == i_size_m1);
  assign o_wait      = i_arrive & ~o_dup & ~o_fire;
  assign o_rel_wmask = r_wait_mask | w_onehot;

  // Mask/count update: clear on completion, accumulate on a waiting arrival.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_mask  <= '0;
      r_arrive_cnt <= '0;
    end else if (o_fire) begin
      r_wait_mask  <= '0;
      r_arrive_cnt <= '0;
    end else if (o_wait) begin
      r_wait_mask  <= r_wait_mask | w_onehot;
      r_arrive_cnt <= r_arrive_cnt + NW_BITS'(1);
    end else begin
      r_wait_mask  <= r_wait_mask;
      r_arrive_cnt <= r_arrive_cnt;
    end
  end

endmodule

// File: rtl/vx_barrier_unit.sv
// Barrier unit top: routes each request to its barrier entry, keeps the
// aggregate stall mask incrementally, and registers the release pulse.
module vx_barrier_unit
  import vx_barrier_unit_pkg::*;
(
  input logic              clk,
  input logic              reset,
  vx_barrier_unit_if.slave bar_if
);

  barrier_req_t         w_req;
  barrier_rel_t         w_rel_next;
  barrier_rel_t         r_rel;
  logic [NUM_WARPS-1:0] r_stalled_wmask;
  logic [31:0]          r_perf_releases;

  logic [NUM_BARRIERS-1:0] w_fire_vec;
  logic [NUM_BARRIERS-1:0] w_wait_vec;
  logic [NUM_BARRIERS-1:0] w_dup_vec;
  logic [NUM_WARPS-1:0]    w_rel_wmask_arr [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    w_sel_rel_wmask;
  logic                    w_fire;
  logic                    w_wait;

  assign w_req.valid   = bar_if.req_valid;
  assign w_req.wid     = bar_if.req_wid;
  assign w_req.id      = bar_if.req_id;
  assign w_req.size_m1 = bar_if.req_size_m1;

  for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_entry
    vx_barrier_unit_entry u_entry (
      .clk         (clk),
      .reset       (reset),
      .i_arrive    (w_req.valid && (w_req.id == NB_BITS'(g))),
      .i_wid       (w_req.wid),
      .i_size_m1   (w_req.size_m1),
      .o_rel_wmask (w_rel_wmask_arr[g]),
      .o_fire      (w_fire_vec[g]),
      .o_wait      (w_wait_vec[g]),
      .o_dup       (w_dup_vec[g])
    );
  end

  // Only the addressed entry can fire or wait, so a plain OR and ID mux suffice.
  assign w_fire          = |w_fire_vec;
  assign w_wait          = |w_wait_vec;
  assign w_sel_rel_wmask = w_rel_wmask_arr[w_req.id];

  // Next release record; zeroed whenever no barrier completes this cycle.
  always_comb begin
    w_rel_next = '0;
    if (w_fire) begin
      w_rel_next.valid = 1'b1;
      w_rel_next.id    = w_req.id;
      w_rel_next.wmask = w_sel_rel_wmask;
    end else begin
      w_rel_next = '0;
    end
  end

  // Registered outputs: release pulse, incremental stall mask, completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rel           <= '0;
      r_stalled_wmask <= '0;
      r_perf_releases <= 32'd0;
    end else begin
      r_rel <= w_rel_next;
      if (w_wait) begin
        r_stalled_wmask <= r_stalled_wmask | wid_onehot(w_req.wid);
      end else if (w_fire) begin
        r_stalled_wmask <= r_stalled_wmask & ~w_sel_rel_wmask;
      end else begin
        r_stalled_wmask <= r_stalled_wmask;
      end
      if (w_fire) begin
        r_perf_releases <= r_perf_releases + 32'd1;
      end else begin
        r_perf_releases <= r_perf_releases;
      end
    end
  end

  assign bar_if.stalled_wmask = r_stalled_wmask;
  assign bar_if.release_valid = r_rel.valid;
  assign bar_if.release_id    = r_rel.id;
  assign bar_if.release_wmask = r_rel.wmask;
  assign bar_if.perf_releases = r_perf_releases;

  vx_barrier_unit_chk u_chk (
    .clk             (clk),
    .reset           (reset),
    .i_req_valid     (w_req.valid),
    .i_req_wid       (w_req.wid),
    .i_stalled_wmask (r_stalled_wmask),
    .i_dup           (|w_dup_vec)
  );

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Self-checking bench for vx_barrier_unit: directed vector table, a hand-written
// back-to-back sequence, then random arrivals against a queue-based model.
module tb_vx_barrier_unit;
  import vx_barrier_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  vx_barrier_unit_if bif();

  vx_barrier_unit dut (
    .clk    (clk),
    .reset  (reset),
    .bar_if (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  wid;
    logic [1:0]  id;
    logic [1:0]  sm;
    logic [3:0]  e_stall;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [3:0]  e_wm;
    logic [31:0] e_perf;
  } vec_t;

  vec_t tbl[$];

  // Model state: per-barrier list of waiting warps, plus completion count.
  int          q [NUM_BARRIERS][$];
  logic [31:0] m_perf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic valid, input logic [1:0] wid,
                       input logic [1:0] id, input logic [1:0] sm);
    @(negedge clk);
    reset            = rst;
    bif.req_valid    = valid;
    bif.req_wid      = wid;
    bif.req_id       = id;
    bif.req_size_m1  = sm;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_stall, input logic e_rv,
                            input logic [1:0] e_id, input logic [3:0] e_wm, input logic [31:0] e_perf);
    check({tag, ".stalled"}, 32'(bif.stalled_wmask), 32'(e_stall));
    check({tag, ".rel_valid"}, 32'(bif.release_valid), 32'(e_rv));
    if (e_rv) begin
      check({tag, ".rel_id"}, 32'(bif.release_id), 32'(e_id));
      check({tag, ".rel_wmask"}, 32'(bif.release_wmask), 32'(e_wm));
    end
    check({tag, ".perf"}, bif.perf_releases, e_perf);
  endtask

  function automatic logic [3:0] model_stalled();
    logic [3:0] m;
    m = 4'b0000;
    for (int b = 0; b < NUM_BARRIERS; b++)
      foreach (q[b][k]) m[q[b][k]] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NUM_BARRIERS; b++) q[b].delete();
    m_perf = 32'd0;
  endtask

  initial begin
    reset           = 1'b1;
    bif.req_valid   = 1'b0;
    bif.req_wid     = 2'd0;
    bif.req_id      = 2'd0;
    bif.req_size_m1 = 2'd0;

    //            rst  valid wid   id    sm    stall    rv    rid   rwm      perf
    tbl.push_back('{1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 32'd0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 32'd0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 2'd1, 2'd3, 4'b0001, 1'b0, 2'd0, 4'b0000, 32'd0});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 2'd1, 2'd3, 4'b0011, 1'b0, 2'd0, 4'b0000, 32'd0});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 2'd1, 2'd3, 4'b0111, 1'b0, 2'd0, 4'b0000, 32'd0});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 2'd1, 2'd3, 4'b0000, 1'b1, 2'd1, 4'b1111, 32'd1});
    tbl.push_back('{1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 32'd1});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 4'b0000, 1'b1, 2'd0, 4'b0100, 32'd2});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 2'd2, 2'd1, 4'b0001, 1'b0, 2'd0, 4'b0000, 32'd2});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 2'd3, 2'd1, 4'b0011, 1'b0, 2'd0, 4'b0000, 32'd2});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 2'd3, 2'd1, 4'b0001, 1'b1, 2'd3, 4'b1010, 32'd3});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 2'd2, 2'd1, 4'b0000, 1'b1, 2'd2, 4'b0101, 32'd4});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 2'd1, 2'd1, 4'b0001, 1'b0, 2'd0, 4'b0000, 32'd4});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 2'd1, 2'd1, 4'b0001, 1'b0, 2'd0, 4'b0000, 32'd4});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 2'd1, 2'd1, 4'b0000, 1'b1, 2'd1, 4'b0011, 32'd5});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 2'd1, 2'd3, 4'b0001, 1'b0, 2'd0, 4'b0000, 32'd5});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 2'd1, 2'd3, 4'b0011, 1'b0, 2'd0, 4'b0000, 32'd5});
    tbl.push_back('{1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 32'd0});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 2'd1, 2'd1, 4'b0100, 1'b0, 2'd0, 4'b0000, 32'd0});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 2'd1, 2'd1, 4'b0000, 1'b1, 2'd1, 4'b1100, 32'd1});

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].wid, tbl[i].id, tbl[i].sm);
      check_outs($sformatf("row%0d", i), tbl[i].e_stall, tbl[i].e_rv, tbl[i].e_id,
                 tbl[i].e_wm, tbl[i].e_perf);
    end

    // Back-to-back single-warp completions, then confirm the pulse drops.
    drive(1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
    check_outs("b2b0", 4'b0000, 1'b1, 2'd0, 4'b0001, 32'd2);
    drive(1'b0, 1'b1, 2'd1, 2'd3, 2'd0);
    check_outs("b2b1", 4'b0000, 1'b1, 2'd3, 4'b0010, 32'd3);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    check_outs("b2b2", 4'b0000, 1'b0, 2'd0, 4'b0000, 32'd3);

    // Random phase against the model.
    drive(1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
    model_reset();
    check_outs("rnd_rst", 4'b0000, 1'b0, 2'd0, 4'b0000, 32'd0);
    for (int it = 0; it < 400; it++) begin
      logic [3:0]  st;
      logic [3:0]  e_wm;
      logic [1:0]  wid, id, sm;
      logic        e_rv;
      st   = model_stalled();
      e_rv = 1'b0;
      e_wm = 4'b0000;
      id   = 2'd0;
      if (st == 4'b1111) begin
        drive(1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        model_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 2'(($urandom_range(0, 3))), 2'(($urandom_range(0, 3))), 2'd0);
      end else begin
        do wid = 2'($urandom_range(0, 3)); while (st[wid]);
        id = 2'($urandom_range(0, 3));
        sm = 2'($urandom_range(0, 3));
        drive(1'b0, 1'b1, wid, id, sm);
        if (q[id].size() == int'(sm)) begin
          e_rv = 1'b1;
          e_wm[wid] = 1'b1;
          foreach (q[id][k]) e_wm[q[id][k]] = 1'b1;
          q[id].delete();
          m_perf = m_perf + 32'd1;
        end else begin
          q[id].push_back(int'(wid));
        end
      end
      check_outs($sformatf("rnd%0d", it), model_stalled(), e_rv, id, e_wm, m_perf);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_barrier_unit.md
Name: VX_barrier_unit

Overview:
- Consumes the barrier field of warp-control responses committed by the GPU unit.
- Tracks arrivals per barrier ID, holds arriving warps stalled, and releases every waiting warp once the programmed count is reached.
- Sits between the warp-control interface and the warp scheduler. Its stall mask gates warp selection; its release pulse un-stalls warps.

Parameters:
- NUM_WARPS, 4, number of hardware warps. Stall/release mask width; NW_BITS = clog2(NUM_WARPS), minimum 1.
- NUM_BARRIERS, 4, number of barrier IDs. NB_BITS = clog2(NUM_BARRIERS), minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  barrier request. Already qualified by commit fire and barrier.valid; no backpressure.
- req_wid  in  NW_BITS  arriving warp ID
- req_id  in  NB_BITS  barrier ID
- req_size_m1  in  NW_BITS  number of participating warps minus 1
- stalled_wmask  out  NUM_WARPS  warps currently held at any barrier (registered)
- release_valid  out  1  one-cycle pulse: a barrier completed
- release_id  out  NB_BITS  barrier that completed
- release_wmask  out  NUM_WARPS  warps freed by this release, including the final arriver
- perf_releases  out  32  count of completed barriers; wraps at 2^32

Behaviour:
- Per-barrier state: wait_mask[NUM_WARPS] and arrive_cnt[NW_BITS]. Each barrier is IDLE (mask 0) or WAITING (mask != 0).
- Reset: all wait_masks, arrive_cnts, stalled_wmask, release_valid, release_id, release_wmask and perf_releases are 0.
- Arrival (req_valid=1 at edge t), indexed by req_id, with the comparison done against this request's req_size_m1:
  - If arrive_cnt == req_size_m1 (release):
    - At t+1: release_valid=1, release_id=req_id, release_wmask = wait_mask | onehot(req_wid).
    - The entry is cleared (mask 0, cnt 0) and perf_releases increments.
    - The final arriver is never set in stalled_wmask.
  - Otherwise (wait):
    - wait_mask |= onehot(req_wid) and arrive_cnt += 1, visible at t+1.
    - stalled_wmask[req_wid] = 1 from t+1.
- req_size_m1 = 0: immediate release of the arriving warp alone. release_wmask = onehot(req_wid); stalled_wmask is unchanged.
- Released warps have their stalled_wmask bits cleared at t+1, the same cycle release_valid is asserted.
- Latency: one cycle from request to updated outputs. At most one request per cycle, so there is no intra-cycle arrival conflict.
- Duplicate arrival (req_wid already set in the target barrier's mask): the request is dropped, with no count change and no release. A simulation-only assertion fires.
- A warp waiting on one barrier cannot issue, so it never arrives at a second barrier. A simulation-only assertion checks that stalled_wmask[req_wid]==0 on every request.
- Multiple barriers may be WAITING at once. stalled_wmask is the OR of all wait_masks and is maintained as its own register, updated incrementally.
- release_valid is high for exactly one cycle per completion. Back-to-back completions (on any IDs) produce back-to-back pulses.
- arrive_cnt never exceeds NUM_WARPS-1; a release always fires before wrap.
- Reset asserted mid-operation aborts all barriers. Every stalled warp is freed with no release pulse; the scheduler is reset at the same time.

Decomposition:
- Shared gpu_types package:
  - struct barrier_req_t {valid, wid, id, size_m1};
  - struct barrier_rel_t {valid, id, wmask};
  - localparams NB_BITS and NW_BITS.
- One natural sub-module: VX_barrier_entry. It holds one barrier's mask and counter and is instantiated NUM_BARRIERS times.
- The top level does ID decode, the stall-mask OR-update, release muxing and the perf counter.

Test Plan (NUM_WARPS=4, NUM_BARRIERS=4):
- Reset, then idle 5 cycles -> stalled_wmask=0000, release_valid=0, perf_releases=0.
- Warps 0,1,2 arrive on id 1 with size_m1=3 on consecutive cycles -> stalled_wmask goes 0001, 0011, 0111. Warp 3 arrives -> next cycle release_valid=1, release_id=1, release_wmask=1111, stalled_wmask=0000, perf_releases=1.
- Warp 2 arrives on id 0 with size_m1=0 -> next cycle release_wmask=0100, stalled_wmask stays 0000.
- Interleaving: w0 id2 (size_m1=1), w1 id3 (size_m1=1), w3 id3, w2 id2 -> releases id3 (wmask=1010) then id2 (wmask=0101) on consecutive cycles. stalled_wmask is 0001, 0011, 0001, 0000 after each request.
- Duplicate: w0 arrives twice on id1 (size_m1=1) -> second request ignored, no release, stalled_wmask=0001, assertion logged. Then w1 arrives -> release_wmask=0011.
- Reset while warps 0,1 are waiting on id1 -> stalled_wmask=0000 next cycle, no release pulse. A fresh barrier on id1 then starts its count from 0.
